// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-requester arbiter:
// opcode encodings, the highest legal opcode and the arbiter FSM states.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_MOD = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;

  localparam logic [3:0] OP_LAST = OP_SHR;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU. Flags f = {div_by_zero, overflow, negative, carry, zero};
// shifts move by one position and put the bit shifted out into carry.
module ALU
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int FW    = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] y,
  output logic [FW-1:0]    f
);

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic               c;
  logic               v;
  logic               dz;

  always_comb begin
    y    = '0;
    c    = 1'b0;
    v    = 1'b0;
    dz   = 1'b0;
    sum  = '0;
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    case (op)
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        y   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sum = {1'b0, a} - {1'b0, b};
        y   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MUL: begin
        y = prod[WIDTH-1:0];
        c = |prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        if (b == '0) dz = 1'b1;
        else         y  = a / b;
      end
      OP_MOD: begin
        if (b == '0) dz = 1'b1;
        else         y  = a % b;
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SHL: begin
        y = {a[WIDTH-2:0], 1'b0};
        c = a[WIDTH-1];
      end
      OP_SHR: begin
        y = {1'b0, a[WIDTH-1:1]};
        c = a[0];
      end
      default: ;
    endcase
    f = FW'({dz, v, y[WIDTH-1], c, (y == '0)});
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters; each
// accepted command yields exactly one tagged, registered response.
module alu_arbiter #(
  parameter int         WIDTH   = 4,
  parameter int         FW      = 5,
  parameter logic [3:0] OP_LAST = alu_pkg::OP_LAST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
  output logic [FW-1:0]    rsp_f,
  output logic             rsp_err,
  output logic             busy
);

  import alu_pkg::*;

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic             gnt_vld;
  logic             gnt_id;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [3:0]       op_p0;
  logic             id_p0;
  logic [WIDTH-1:0] alu_y;
  logic [FW-1:0]    alu_f;

  // Ties go to the requester that did not win last time.
  always_comb begin
    gnt_vld = (state == IDLE) && !rst && (req0_valid || req1_valid);
    gnt_id  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld)   state_nxt = EXEC;
      EXEC:                   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = gnt_vld && !gnt_id;
    req1_ready = gnt_vld && gnt_id;
    rsp_valid  = (state == RESP);
    busy       = (state != IDLE);
  end

  // Stage p0: operands captured on the grant edge, they feed the ALU in EXEC.
  always_ff @(posedge clk) begin
    if (gnt_vld) begin
      a_p0  <= gnt_id ? req1_a  : req0_a;
      b_p0  <= gnt_id ? req1_b  : req0_b;
      op_p0 <= gnt_id ? req1_op : req0_op;
      id_p0 <= gnt_id;
    end
  end

  ALU #(
    .WIDTH(WIDTH),
    .FW   (FW)
  ) u_alu (
    .a (a_p0),
    .b (b_p0),
    .op(op_p0),
    .y (alu_y),
    .f (alu_f)
  );

  // Stage p1: result registers, loaded at the end of EXEC and held through RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      rsp_id     <= 1'b0;
      rsp_y      <= '0;
      rsp_f      <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (gnt_vld) last_grant <= gnt_id;
      if (state == EXEC) begin
        rsp_id <= id_p0;
        if (op_p0 > OP_LAST) begin
          rsp_y   <= '0;
          rsp_f   <= '0;
          rsp_err <= 1'b1;
        end else begin
          rsp_y   <= alu_y;
          rsp_f   <= alu_f;
          rsp_err <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: table of single transactions with
// hand-computed results, plus sequences for arbitration, backpressure and reset.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready;
  logic [3:0] req0_a, req0_b, req0_op;
  logic       req1_valid, req1_ready;
  logic [3:0] req1_a, req1_b, req1_op;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [3:0] rsp_y;
  logic [4:0] rsp_f;
  logic       rsp_err, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_op   (req0_op),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_op   (req1_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_f     (rsp_f),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  typedef struct {
    bit         id;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
    logic [3:0] y;
    logic [4:0] f;
    bit         err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input bit id, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] op, input bit v);
    if (id == 1'b0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t t);
    int   n;
    logic rdy;
    drive_req(t.id, t.a, t.b, t.op, 1'b1);
    #1;
    n   = 0;
    rdy = t.id ? req1_ready : req0_ready;
    while (!rdy && n < 10) begin
      step();
      n++;
      rdy = t.id ? req1_ready : req0_ready;
    end
    chk("grant", rdy, 1);
    step();
    drive_req(t.id, t.a, t.b, t.op, 1'b0);
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_busy", busy, 1);
    step();
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, t.id);
    chk("rsp_y", rsp_y, t.y);
    chk("rsp_f", rsp_f, t.f);
    chk("rsp_err", rsp_err, t.err);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("drain_valid", rsp_valid, 0);
    chk("drain_busy", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int         cnt;
    int         ids[4];
    logic [3:0] ys[4];
    int         cyc[4];

    // {id, a, b, op, y, f, err}; f = {dz, v, n, c, z}
    vecs[0] = '{1'b0, 4'b1011, 4'b0011, 4'b0000, 4'b1110, 5'b00100, 1'b0}; // ADD
    vecs[1] = '{1'b0, 4'b1011, 4'b0001, 4'b1000, 4'b0110, 5'b00010, 1'b0}; // SHL
    vecs[2] = '{1'b1, 4'b1011, 4'b0001, 4'b1001, 4'b0101, 5'b00010, 1'b0}; // SHR
    vecs[3] = '{1'b1, 4'b1011, 4'b0011, 4'b1100, 4'b0000, 5'b00000, 1'b1}; // illegal op
    vecs[4] = '{1'b1, 4'b0011, 4'b1011, 4'b0001, 4'b1000, 5'b01110, 1'b0}; // SUB, overflow
    vecs[5] = '{1'b0, 4'b1011, 4'b0000, 4'b0011, 4'b0000, 5'b10001, 1'b0}; // DIV by zero
    vecs[6] = '{1'b1, 4'b0011, 4'b0101, 4'b0010, 4'b1111, 5'b00100, 1'b0}; // MUL
    vecs[7] = '{1'b0, 4'b1011, 4'b0011, 4'b0100, 4'b0010, 5'b00000, 1'b0}; // remainder

    rst = 1'b1;
    rsp_ready = 1'b0;
    drive_req(1'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    drive_req(1'b1, 4'b0, 4'b0, 4'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_y", rsp_y, 0);
    chk("reset_rsp_f", rsp_f, 0);
    chk("reset_rsp_err", rsp_err, 0);

    // Both requesters valid while still in reset: no grant until rst drops.
    drive_req(1'b0, 4'b1011, 4'b0011, 4'b0101, 1'b1);
    drive_req(1'b1, 4'b1011, 4'b0011, 4'b0111, 1'b1);
    #1;
    chk("reset_req0_ready", req0_ready, 0);
    chk("reset_req1_ready", req1_ready, 0);
    step();
    rst = 1'b0;
    #1;
    chk("tie_req0_ready", req0_ready, 1);
    chk("tie_req1_ready", req1_ready, 0);

    rsp_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 40 && cnt < 4; c++) begin
      if (rsp_valid) begin
        ids[cnt] = rsp_id;
        ys[cnt]  = rsp_y;
        cyc[cnt] = c;
        cnt++;
      end
      if (cnt < 4) step();
    end
    chk("rr_count", cnt, 4);
    if (cnt == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("rr_id", ids[i], i % 2);
        chk("rr_y", ys[i], (i % 2 == 0) ? 4'b0011 : 4'b1000);
      end
      chk("rr_first_latency", cyc[0], 2);
      for (int i = 1; i < 4; i++) chk("rr_interval", cyc[i] - cyc[i-1], 3);
    end
    drive_req(1'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    drive_req(1'b1, 4'b0, 4'b0, 4'b0, 1'b0);
    step();
    rsp_ready = 1'b0;
    chk("rr_idle", busy, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: response held while req1 waits.
    drive_req(1'b0, 4'b1011, 4'b0011, 4'b0110, 1'b1);
    #1;
    chk("bp_grant", req0_ready, 1);
    step();
    drive_req(1'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    drive_req(1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b1);
    #1;
    chk("bp_exec_req1_ready", req1_ready, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_y", rsp_y, 4'b1011);
      chk("bp_req1_ready", req1_ready, 0);
      chk("bp_busy", busy, 1);
      step();
    end
    chk("bp_still_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_released", rsp_valid, 0);
    chk("bp_pending_grant", req1_ready, 1);
    step();
    drive_req(1'b1, 4'b0, 4'b0, 4'b0, 1'b0);
    step();
    chk("bp2_valid", rsp_valid, 1);
    chk("bp2_id", rsp_id, 1);
    chk("bp2_y", rsp_y, 4'b0010);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Reset during EXEC discards the command in flight.
    drive_req(1'b0, 4'b1011, 4'b0011, 4'b0000, 1'b1);
    #1;
    chk("rx_grant", req0_ready, 1);
    step();
    drive_req(1'b0, 4'b0, 4'b0, 4'b0, 1'b0);
    chk("rx_in_exec", busy, 1);
    rst = 1'b1;
    step();
    chk("rx_rsp_valid", rsp_valid, 0);
    chk("rx_busy", busy, 0);
    chk("rx_rsp_id", rsp_id, 0);
    chk("rx_rsp_y", rsp_y, 0);
    chk("rx_rsp_f", rsp_f, 0);
    chk("rx_rsp_err", rsp_err, 0);
    rst = 1'b0;
    drive_req(1'b1, 4'b1011, 4'b0011, 4'b0111, 1'b1);
    #1;
    chk("rx_next_grant", req1_ready, 1);
    step();
    drive_req(1'b1, 4'b0, 4'b0, 4'b0, 1'b0);
    chk("rx_no_stale_rsp", rsp_valid, 0);
    step();
    chk("rx_rsp_valid2", rsp_valid, 1);
    chk("rx_rsp_id2", rsp_id, 1);
    chk("rx_rsp_y2", rsp_y, 4'b1000);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rx_done", rsp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
